// File: rtl/mul_booth_issue_if.sv
// Request channel from EX into the multiplier front end.
interface mul_booth_issue_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic [XLEN-1:0] req_rs1;
    logic [XLEN-1:0] req_rs2;

    modport master (output req_valid, req_op, req_rs1, req_rs2, input  req_ready);
    modport slave  (input  req_valid, req_op, req_rs1, req_rs2, output req_ready);
endinterface

// File: rtl/mul_booth_issue.sv
// Multiplier front end: one-entry stage, radix-4 Booth partial products transposed
// into per-column vectors, credit-paced issue and a completion strobe aligned to the trees.
module mul_booth_issue #(
    parameter int XLEN      = 32,
    parameter int NPP       = XLEN/2 + 1,
    parameter int COLS      = 2*XLEN,
    parameter int TREE_LAT  = 1,
    parameter int RES_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cancel,
    mul_booth_issue_if.slave     req,
    output logic                 pp_valid_o,
    output logic [COLS*NPP-1:0]  pp_cols_o,
    output logic [1:0]           pp_op_o,
    input  logic                 credit_ret_i,
    output logic                 cpl_valid_o,
    output logic [1:0]           cpl_op_o
);
    localparam int CW = $clog2(RES_DEPTH + 1);

    typedef enum logic {S_EMPTY, S_FULL} state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       credits_q, credits_d;
    logic [1:0]          stg_op_q;
    logic [XLEN-1:0]     stg_rs1_q, stg_rs2_q;
    logic                issue_now, accept, ret_ok;

    logic                pp_valid_q;
    logic [COLS*NPP-1:0] pp_cols_q, cols_d;
    logic [1:0]          pp_op_q;
    logic [TREE_LAT-1:0]      cpl_vld_q;
    logic [TREE_LAT-1:0][1:0] cpl_op_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_EMPTY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (cancel) state_d = S_EMPTY;
        else begin
            case (state_q)
                S_EMPTY: if (accept)                state_d = S_FULL;
                S_FULL:  if (issue_now && !accept) state_d = S_EMPTY;
            endcase
        end
    end

    // Ready never looks at req_valid, so the requester sees no comb loop.
    always_comb begin
        issue_now     = (state_q == S_FULL) && (credits_q != '0) && !cancel;
        req.req_ready = !cancel && ((state_q == S_EMPTY) || issue_now);
        accept        = req.req_valid && req.req_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_op_q  <= '0;
            stg_rs1_q <= '0;
            stg_rs2_q <= '0;
        end else if (accept) begin
            stg_op_q  <= req.req_op;
            stg_rs1_q <= req.req_rs1;
            stg_rs2_q <= req.req_rs2;
        end
    end

    // A return with every credit already home is dropped; the result stage broke protocol.
    always_comb begin
        ret_ok    = credit_ret_i && (credits_q != CW'(RES_DEPTH));
        credits_d = credits_q;
        if (cancel)                     credits_d = CW'(RES_DEPTH);
        else if (issue_now && !ret_ok)  credits_d = credits_q - 1'b1;
        else if (ret_ok && !issue_now)  credits_d = credits_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) credits_q <= CW'(RES_DEPTH);
        else     credits_q <= credits_d;
    end

    a_ret_ovf: assert property (@(posedge clk) disable iff (rst)
        !(credit_ret_i && !cancel && credits_q == CW'(RES_DEPTH)));

    logic                 s1, s2;
    logic [COLS-1:0]      a1, a2;
    logic [XLEN+2:0]      mx;
    logic [NPP-1:0][COLS-1:0] pp;

    always_comb begin
        s1 = (stg_op_q == 2'b01) || (stg_op_q == 2'b10);
        s2 = (stg_op_q == 2'b01);
        a1 = {{(COLS-XLEN){s1 & stg_rs1_q[XLEN-1]}}, stg_rs1_q};
        a2 = a1 << 1;
        mx = {{2{s2 & stg_rs2_q[XLEN-1]}}, stg_rs2_q, 1'b0};
    end

    // Each row is a full two's-complement multiple of rs1, so no correction row is needed.
    for (genvar i = 0; i < NPP; i++) begin : g_row
        logic [2:0]      grp;
        logic [COLS-1:0] row;
        assign grp = mx[2*i+2 -: 3];
        always_comb begin
            case (grp)
                3'b001, 3'b010: row = a1;
                3'b011:         row = a2;
                3'b100:         row = -a2;
                3'b101, 3'b110: row = -a1;
                default:        row = '0;
            endcase
        end
        assign pp[i] = row << (2*i);
    end

    always_comb begin
        cols_d = '0;
        for (int j = 0; j < COLS; j++)
            for (int k = 0; k < NPP; k++)
                cols_d[j*NPP+k] = pp[k][j];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pp_valid_q <= 1'b0;
            pp_cols_q  <= '0;
            pp_op_q    <= '0;
        end else begin
            pp_valid_q <= issue_now;
            if (issue_now) begin
                pp_cols_q <= cols_d;
                pp_op_q   <= stg_op_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpl_vld_q <= '0;
            cpl_op_q  <= '0;
        end else begin
            cpl_vld_q[0] <= pp_valid_q && !cancel;
            cpl_op_q[0]  <= pp_op_q;
            for (int i = 1; i < TREE_LAT; i++) begin
                cpl_vld_q[i] <= cpl_vld_q[i-1] && !cancel;
                cpl_op_q[i]  <= cpl_op_q[i-1];
            end
        end
    end

    assign pp_valid_o  = pp_valid_q;
    assign pp_cols_o   = pp_cols_q;
    assign pp_op_o     = pp_op_q;
    assign cpl_valid_o = cpl_vld_q[TREE_LAT-1];
    assign cpl_op_o    = cpl_op_q[TREE_LAT-1];
endmodule

// File: tb/tb_mul_booth_issue.sv
// Scoreboarded bench for mul_booth_issue: column sums against an integer product model,
// credit pacing, cancel and asynchronous reset.
module tb_mul_booth_issue;
    localparam int XLEN = 32, NPP = 17, COLS = 64;

    logic clk = 1'b0, rst = 1'b1, cancel = 1'b0, credit_ret_i = 1'b0;
    logic pp_valid_o, cpl_valid_o;
    logic [COLS*NPP-1:0] pp_cols_o;
    logic [1:0] pp_op_o, cpl_op_o;

    mul_booth_issue_if #(.XLEN(XLEN)) rq();

    mul_booth_issue dut (
        .clk(clk), .rst(rst), .cancel(cancel), .req(rq),
        .pp_valid_o(pp_valid_o), .pp_cols_o(pp_cols_o), .pp_op_o(pp_op_o),
        .credit_ret_i(credit_ret_i), .cpl_valid_o(cpl_valid_o), .cpl_op_o(cpl_op_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [1:0] op; logic [63:0] prod; } exp_t;
    exp_t sb[$];
    int checks = 0, errs = 0, n_iss = 0;
    logic last_pp = 1'b0, last_can = 1'b0;
    logic [1:0] last_op = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] x, y;
        x = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
        y = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
        return x * y;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            last_pp = 1'b0; last_can = 1'b0; last_op = '0;
        end else begin
            chk("cpl_valid", 64'(cpl_valid_o), 64'(last_pp && !last_can));
            if (last_pp && !last_can) chk("cpl_op", 64'(cpl_op_o), 64'(last_op));
            if (pp_valid_o) begin
                logic [63:0] s;
                exp_t e;
                n_iss++;
                s = '0;
                for (int j = 0; j < COLS; j++)
                    for (int k = 0; k < NPP; k++)
                        if (pp_cols_o[j*NPP+k]) s += 64'(1) << j;
                if (sb.size() == 0) chk("spurious_issue", 64'(1), 64'(0));
                else begin
                    e = sb.pop_front();
                    chk("pp_sum", s, e.prod);
                    chk("pp_op", 64'(pp_op_o), 64'(e.op));
                end
            end
            last_pp = pp_valid_o; last_op = pp_op_o; last_can = cancel;
        end
    end

    // One cycle of stimulus; er >= 0 also checks req_ready for that cycle.
    task automatic cyc(input bit v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input bit can, input bit ret, input int er);
        bit acc;
        rq.req_valid = v; rq.req_op = op; rq.req_rs1 = a; rq.req_rs2 = b;
        cancel = can; credit_ret_i = ret;
        @(negedge clk);
        if (er >= 0) chk("req_ready", 64'(rq.req_ready), 64'(er));
        acc = v && rq.req_ready;
        @(posedge clk);
        if (acc) sb.push_back('{op, exp});
        if (can) sb.delete();
        #1;
        rq.req_valid = 1'b0; cancel = 1'b0; credit_ret_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 2'b00, '0, '0, '0, 0, 0, -1);
    endtask

    task automatic ret1();
        cyc(0, 2'b00, '0, '0, '0, 0, 1, -1);
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int er);
        cyc(1, op, a, b, model(op, a, b), 0, 0, er);
    endtask

    initial begin
        int n0;
        logic [1:0] op;
        logic [31:0] a, b;
        rq.req_valid = 1'b0; rq.req_op = '0; rq.req_rs1 = '0; rq.req_rs2 = '0;

        // reset values
        @(negedge clk);
        chk("rst_pp_valid", 64'(pp_valid_o), 64'(0));
        chk("rst_cpl_valid", 64'(cpl_valid_o), 64'(0));
        chk("rst_cols", 64'(|pp_cols_o), 64'(0));
        chk("rst_pp_op", 64'(pp_op_o), 64'(0));
        chk("rst_cpl_op", 64'(cpl_op_o), 64'(0));
        chk("rst_ready", 64'(rq.req_ready), 64'(1));
        @(posedge clk); #1 rst = 1'b0;

        // MULHU all-ones
        cyc(1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, 0, 1);
        idle(3); ret1();

        // signed corners and back-to-back issue until credits run out
        cyc(1, 2'b01, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0, 0, 1);
        cyc(1, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0001, 0, 0, 1);
        send(2'b00, 32'd7, 32'hFFFF_FFFD, 1);
        cyc(0, 2'b00, '0, '0, '0, 0, 0, 0);
        cyc(0, 2'b00, '0, '0, '0, 0, 1, 0);
        idle(3); ret1(); ret1();

        // three requests, two credits
        n0 = n_iss;
        send(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 1);
        send(2'b01, 32'hDEAD_BEEF, 32'h0000_0005, 1);
        send(2'b10, 32'h7FFF_FFFF, 32'h8000_0001, 1);
        cyc(0, 2'b00, '0, '0, '0, 0, 0, 0);
        idle(2);
        chk("t4_two_issues", 64'(n_iss - n0), 64'd2);
        ret1(); idle(1);
        @(negedge clk);
        chk("t4_issue_after_ret", 64'(pp_valid_o), 64'(1));
        @(posedge clk); #1;
        chk("t4_three_issues", 64'(n_iss - n0), 64'd3);
        idle(1); ret1(); ret1();

        // issue and return in the same cycle with one credit left
        n0 = n_iss;
        send(2'b11, 32'h0000_FFFF, 32'hFFFF_0000, 1);
        send(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 1);
        cyc(1, 2'b01, 32'h0000_0003, 32'hFFFF_FFFF, model(2'b01, 32'h3, 32'hFFFF_FFFF), 0, 1, 1);
        send(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        cyc(0, 2'b00, '0, '0, '0, 0, 0, 0);
        chk("t5_no_gap", 64'(n_iss - n0), 64'd3);
        cyc(0, 2'b00, '0, '0, '0, 0, 0, 0);
        chk("t5_held", 64'(n_iss - n0), 64'd3);
        ret1(); idle(2);
        chk("t5_after_ret", 64'(n_iss - n0), 64'd4);
        ret1(); ret1();

        // cancel with one op in the stage and one in the trees
        n0 = n_iss;
        send(2'b11, 32'h0000_0010, 32'h0000_0020, 1);
        send(2'b11, 32'h0000_0030, 32'h0000_0040, 1);
        cyc(0, 2'b00, '0, '0, '0, 1, 0, 0);
        send(2'b00, 32'h0000_0011, 32'h0000_0013, 1);
        send(2'b01, 32'hFFFF_FFF0, 32'h0000_0100, 1);
        send(2'b10, 32'h0000_0002, 32'h8000_0000, 1);
        cyc(0, 2'b00, '0, '0, '0, 0, 0, 0);
        idle(2);
        chk("t6_issues", 64'(n_iss - n0), 64'd3);
        ret1(); idle(3); ret1(); ret1();

        // asynchronous reset with a full stage and a completion pending
        send(2'b01, 32'h0000_0100, 32'h0000_0200, 1);
        send(2'b11, 32'h0000_0300, 32'h0000_0400, 1);
        rst = 1'b1;
        #2;
        chk("rst_mid_pp_valid", 64'(pp_valid_o), 64'(0));
        chk("rst_mid_cpl_valid", 64'(cpl_valid_o), 64'(0));
        chk("rst_mid_ready", 64'(rq.req_ready), 64'(1));
        sb.delete();
        @(posedge clk); #1 rst = 1'b0;
        n0 = n_iss;
        send(2'b00, 32'h0000_0009, 32'h0000_0009, 1);
        send(2'b11, 32'hCAFE_F00D, 32'h1234_5678, 1);
        idle(3);
        chk("t1_credits_restored", 64'(n_iss - n0), 64'd2);
        ret1(); ret1();

        // random operands, one credit cycled per request
        for (int i = 0; i < 16; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            if (i == 0) begin a = 32'h8000_0000; b = 32'h7FFF_FFFF; end
            if (i == 1) begin a = 32'h0; b = 32'hFFFF_FFFF; end
            send(op, a, b, 1);
            idle(1);
            ret1();
        end
        idle(3);
        chk("sb_drain", 64'(sb.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
